// File: rtl/psum_collector_if.sv
// Column-sample inputs and drained-result stream of the systolic partial-sum collector.
interface psum_collector_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] col0;
  logic [W-1:0] col1;
  logic [W-1:0] col2;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [W-1:0] sum;
  logic         busy;
  logic         done;

  modport master (
    output start, col0, col1, col2, out_ready,
    input  out_data, out_valid, out_last, sum, busy, done
  );

  modport slave (
    input  start, col0, col1, col2, out_ready,
    output out_data, out_valid, out_last, sum, busy, done
  );
endinterface

// File: rtl/psum_collector.sv
// De-skews N systolic columns into an NxN buffer over 2N-1 cycles, then drains it row-major (first word 2N-1 cycles after start).
// Drain is valid/ready: a word holds while out_ready is low, and back-to-back transfers sustain one word per cycle.
module psum_collector #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst,
  psum_collector_if.slave bus
);
  localparam int NW = N * N;
  localparam int CW = $clog2(2 * N);
  localparam int IW = $clog2(NW + 1);
  localparam logic [CW-1:0] CAP_END  = CW'(2 * N - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cyc;
  logic [IW-1:0] idx;
  logic [W-1:0]  buf_q [NW];
  logic [W-1:0]  sum_q;
  logic          done_q;
  logic [W-1:0]  col [N];
  logic [NW-1:0] cap_we;
  logic [W-1:0]  cap_add;
  logic          start_ok;
  logic          xfer;
  logic          xfer_last;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      case (k)
        0:       col[k] = bus.col0;
        1:       col[k] = bus.col1;
        default: col[k] = bus.col2;
      endcase
    end
  end

  assign start_ok  = (state == IDLE) && bus.start;
  assign xfer      = (state == DRAIN) && bus.out_ready;
  assign xfer_last = xfer && (idx == IDX_LAST);

  // The start cycle is capture cycle 0 even though the state register still reads IDLE.
  always_comb begin
    cap_we  = '0;
    cap_add = '0;
    if (start_ok) begin
      cap_we[0] = 1'b1;
      cap_add   = col[0];
    end else if (state == CAPTURE) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cyc) == i + k) begin
            cap_we[i*N+k] = 1'b1;
            cap_add       = cap_add + col[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CAPTURE;
      CAPTURE: if (cyc == CAP_END) state_nxt = DRAIN;
      DRAIN:   if (xfer_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.out_valid = (state == DRAIN);
    bus.out_last  = (state == DRAIN) && (idx == IDX_LAST);
    bus.out_data  = (state == DRAIN) ? buf_q[idx] : '0;
  end

  assign bus.sum  = sum_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc    <= '0;
      idx    <= '0;
      sum_q  <= '0;
      done_q <= 1'b0;
      for (int j = 0; j < NW; j++) begin
        buf_q[j] <= '0;
      end
    end else begin
      done_q <= xfer_last;

      // A new start reseeds the sum; otherwise it only moves while capturing.
      if (start_ok) begin
        sum_q <= cap_add;
      end else if (state == CAPTURE) begin
        sum_q <= sum_q + cap_add;
      end

      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cap_we[i*N+k]) begin
            buf_q[i*N+k] <= col[k];
          end
        end
      end

      if (start_ok) begin
        cyc <= CW'(1);
      end else if (state == CAPTURE) begin
        cyc <= (cyc == CAP_END) ? '0 : cyc + CW'(1);
      end

      if (xfer) begin
        idx <= xfer_last ? '0 : idx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: skewed 3x3 frames, backpressure, wrap, ignored starts, mid-run reset, chained frames.
module tb_psum_collector;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] fv [9];

  psum_collector_if #(.W(8)) bus ();

  psum_collector #(.W(8), .N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.col0      = 8'h00;
    bus.col1      = 8'h00;
    bus.col2      = 8'h00;
    bus.out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // fv holds column k row i at i*3+k, which is also the expected drain order.
  function automatic logic [7:0] col_sample(input int c, input int k);
    int i;
    i = c - k;
    if (i >= 0 && i < 3) return fv[i*3+k];
    return 8'h5A;
  endfunction

  // Cycle 0 is the start cycle; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1.
  task automatic run_frame(input string tag, input int mode, input int xs0, input int xs1,
                           input int rst_at, input logic [7:0] exp_sum);
    int         widx;
    int         last_xfer;
    bit         stalled;
    bit         finished;
    logic [7:0] held;
    widx      = 0;
    last_xfer = -100;
    stalled   = 1'b0;
    finished  = 1'b0;
    held      = 8'h00;
    for (int c = 0; c < 40; c++) begin
      rst           = (c == rst_at);
      bus.start     = (c == 0) || (c == xs0) || (c == xs1);
      bus.col0      = col_sample(c, 0);
      bus.col1      = col_sample(c, 1);
      bus.col2      = col_sample(c, 2);
      bus.out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));

      if (rst_at >= 0 && c == rst_at + 1) begin
        chk({tag, "/rst_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "/rst_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "/rst_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "/rst_sum"},   32'(bus.sum),       32'd0);
        chk({tag, "/rst_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "/rst_done"},  32'(bus.done),      32'd0);
        finished = 1'b1;
        break;
      end

      if (c == 0) begin
        chk({tag, "/busy_c0"}, 32'(bus.busy), 32'd0);
      end else begin
        if (bus.done) begin
          chk({tag, "/done_gap"},   32'(c),             32'(last_xfer + 1));
          chk({tag, "/done_valid"}, 32'(bus.out_valid), 32'd0);
          chk({tag, "/done_busy"},  32'(bus.busy),      32'd0);
          chk({tag, "/words"},      32'(widx),          32'd9);
          chk({tag, "/done_sum"},   32'(bus.sum),       32'(exp_sum));
          if (mode == 0) chk({tag, "/done_cycle"}, 32'(c), 32'd14);
          finished = 1'b1;
          break;
        end
        chk({tag, "/busy"},  32'(bus.busy),      32'd1);
        chk({tag, "/valid"}, 32'(bus.out_valid), 32'(c >= 5));
      end

      if (bus.out_valid) begin
        if (stalled) chk({tag, "/stall_hold"}, 32'(bus.out_data), 32'(held));
        if (widx < 9) begin
          chk({tag, "/data"}, 32'(bus.out_data), 32'(fv[widx]));
          chk({tag, "/last"}, 32'(bus.out_last), 32'(widx == 8));
        end else begin
          chk({tag, "/overrun"}, 32'(widx), 32'd8);
        end
        chk({tag, "/sum"}, 32'(bus.sum), 32'(exp_sum));
        stalled = !bus.out_ready;
        held    = bus.out_data;
        if (bus.out_ready) begin
          widx++;
          last_xfer = c;
        end
      end
      tick();
    end
    if (!finished) chk({tag, "/timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.col0      = 8'h77;
    bus.col1      = 8'h66;
    bus.col2      = 8'h55;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("reset/valid", 32'(bus.out_valid), 32'd0);
    chk("reset/data",  32'(bus.out_data),  32'd0);
    chk("reset/last",  32'(bus.out_last),  32'd0);
    chk("reset/sum",   32'(bus.sum),       32'd0);
    chk("reset/busy",  32'(bus.busy),      32'd0);
    chk("reset/done",  32'(bus.done),      32'd0);
    idle(1);
    chk("reset/start_ignored", 32'(bus.busy), 32'd0);

    fv = '{8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9};
    run_frame("basic", 0, -1, -1, -1, 8'd45);
    idle(3);
    chk("basic/sum_hold",   32'(bus.sum),       32'd45);
    chk("basic/idle_valid", 32'(bus.out_valid), 32'd0);

    run_frame("backpressure", 1, -1, -1, -1, 8'd45);
    idle(2);

    fv = '{default: 8'hF0};
    run_frame("wrap", 0, -1, -1, -1, 8'h70);
    idle(2);

    fv = '{8'd1, 8'd4, 8'd7, 8'd2, 8'd5, 8'd8, 8'd3, 8'd6, 8'd9};
    run_frame("ign_start", 0, 2, 7, -1, 8'd45);
    idle(2);

    run_frame("mid_rst", 0, -1, -1, 3, 8'd0);
    idle(1);
    run_frame("after_rst", 0, -1, -1, -1, 8'd45);
    idle(2);

    run_frame("chain_a", 0, -1, -1, -1, 8'd45);
    fv = '{8'd10, 8'd40, 8'd70, 8'd20, 8'd50, 8'd80, 8'd30, 8'd60, 8'd90};
    run_frame("chain_b", 0, -1, -1, -1, 8'd194);
    idle(2);
    chk("chain_b/sum_hold", 32'(bus.sum), 32'd194);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL provide parameter W, default 8, meaning the data width of each column sample and each output word.
REQ-002 SHALL provide parameter N, default 3, meaning the number of systolic columns and also the number of rows per column.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse coinciding with row-0 sample on col0.
REQ-006 SHALL have ports col0, col1, col2, each an input of W bits: skewed column outputs of the PE array.
REQ-007 SHALL have port out_data, output, W bits: drained result word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-010 SHALL have port out_last, output, 1 bit: the current word is the final word (index N*N-1).
REQ-011 SHALL have port sum, output, W bits: modulo-2^W sum of all captured words.
REQ-012 SHALL have port busy, output, 1 bit: high in CAPTURE or DRAIN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last word transfers.

Function
REQ-014 SHALL implement three states: IDLE, CAPTURE, DRAIN.
REQ-015 IDLE -> CAPTURE on start=1; the sample col0 in that same cycle is stored as buf[0][0].
REQ-016 Capture timing: with start at cycle t, colk row i SHALL be stored in buf[i][k] at cycle t+i+k, for i,k in 0..N-1.
REQ-017 CAPTURE SHALL last exactly 2N-1 cycles (t..t+4 for N=3), counted by a cycle counter; samples outside each column's window SHALL be ignored.
REQ-018 CAPTURE -> DRAIN at the edge ending cycle t+2N-2; out_valid SHALL first be high in cycle t+2N-1 (t+5).
REQ-019 The sum SHALL accumulate during CAPTURE, wrap modulo 2^W, be stable throughout DRAIN, and hold until the next start or rst.
REQ-020 In DRAIN, the block SHALL emit buf row-major: index j = i*N+k, from j=0 to j=N*N-1.
REQ-021 A transfer occurs on a cycle with out_valid&out_ready; the index SHALL then advance on the next edge.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; no word may be dropped or repeated.
REQ-023 out_last SHALL be high only while index = N*N-1 and out_valid=1.
REQ-024 On transfer of the last word, DRAIN -> IDLE; done SHALL be 1 in the following cycle only; out_valid SHALL be 0 in that cycle.
REQ-025 start asserted in CAPTURE or DRAIN SHALL be ignored; start in the same cycle as done SHALL begin a new capture.
REQ-026 out_ready in IDLE or CAPTURE SHALL have no effect.
REQ-027 Back-to-back transfers SHALL sustain one word per cycle; minimum DRAIN length is N*N cycles.

Reset
REQ-028 rst=1 SHALL force state IDLE, index 0, and cycle counter 0 on the next edge, regardless of state, including mid-CAPTURE and mid-DRAIN.
REQ-029 Reset values: out_data=0, out_valid=0, out_last=0, sum=0, busy=0, done=0; all buf entries=0.
REQ-030 start coincident with rst SHALL be ignored.

Verification
REQ-031 Basic: start at t, col0=1,2,3 at t..t+2, col1=4,5,6 at t+1..t+3, col2=7,8,9 at t+2..t+4, out_ready=1 -> out_valid from t+5; words 1,4,7,2,5,8,3,6,9; out_last with 9; sum=45; done at t+14.
REQ-032 Backpressure: same data, out_ready toggling 1,0,0,1 repeating -> identical word order, no duplicates or drops, out_data stable during stalls, done one cycle after the 9th transfer.
REQ-033 Wrap: all nine samples = 8'hF0 -> every word F0; sum = 9*0xF0 mod 256 = 8'h70.
REQ-034 Ignored start: extra start pulses at t+2 and t+7 -> output identical to REQ-031; busy stays high continuously from t+1 until done.
REQ-035 Mid-operation reset: rst at t+3 -> next cycle all outputs 0 and IDLE; a new start two cycles later with the REQ-031 data -> correct full result, sum=45.
REQ-036 Back-to-back frames: start in the done cycle with samples 10..90 -> second frame drains 10,40,70,20,50,80,30,60,90; sum=450 mod 256=194.
